// File: rtl/rezzmaster.sv
// Shared reservation-station types: one station entry and the "no producer" tag.
// Operand fields are sized by RS_XLEN; rs_dispatch's XLEN must equal it.
package rezzmaster;

   localparam int RS_XLEN = 32;
   localparam logic [5:0] RS_TAG_NONE = 6'd0;

   typedef struct packed {
      logic               inuse;
      logic [6:0]         op;
      logic [2:0]         fu;
      logic [RS_XLEN-1:0] vj;
      logic [RS_XLEN-1:0] vk;
      logic [5:0]         qj;
      logic [5:0]         qk;
      logic [5:0]         dest;
   } reservation_station;

endpackage

// File: rtl/rs_dispatch_if.sv
// Decode/CDB/issue-facing signal bundle of the dispatch writer.
// The master side drives requests; the slave side (rs_dispatch) answers and exposes the station.
interface rs_dispatch_if #(
   parameter int NUM_RS = 16,
   parameter int XLEN   = 32
);
   logic                           in_valid;
   logic                           in_ready;
   logic [6:0]                     in_op;
   logic [2:0]                     in_fu;
   logic [XLEN-1:0]                in_vj;
   logic [XLEN-1:0]                in_vk;
   logic [5:0]                     in_qj;
   logic [5:0]                     in_qk;
   logic [5:0]                     in_dest;
   logic [5:0]                     alloc_index;
   logic                           free_valid;
   logic [5:0]                     free_index;
   logic                           cdb_valid;
   logic [5:0]                     cdb_tag;
   logic [XLEN-1:0]                cdb_value;
   rezzmaster::reservation_station rstation [NUM_RS];
   logic [NUM_RS-1:0]              rs_ready;
   logic [6:0]                     free_count;
   logic                           err_double_free;

   modport master (
      output in_valid, in_op, in_fu, in_vj, in_vk, in_qj, in_qk, in_dest,
      output free_valid, free_index, cdb_valid, cdb_tag, cdb_value,
      input  in_ready, alloc_index, rstation, rs_ready, free_count, err_double_free
   );

   modport slave (
      input  in_valid, in_op, in_fu, in_vj, in_vk, in_qj, in_qk, in_dest,
      input  free_valid, free_index, cdb_valid, cdb_tag, cdb_value,
      output in_ready, alloc_index, rstation, rs_ready, free_count, err_double_free
   );
endinterface

// File: rtl/rs_pick_free.sv
// Lowest-set-bit priority encoder; `any` is low when no request bit is set (index then 0).
// Purely combinational, shared with the issue-side selector.
module rs_pick_free #(
   parameter int N = 16
)(
   input  logic [N-1:0] i_req,
   output logic [5:0]   index,
   output logic         any
);
   always_comb begin
      index = 6'd0;
      any   = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            index = 6'(i);
            any   = 1'b1;
         end
      end
   end
endmodule

// File: rtl/rs_dispatch.sv
// Dispatch writer: allocates the lowest free station entry, snoops the CDB, takes releases from issue.
// One-cycle write latency; in_ready comes only from registered inuse bits, so decode may hold in_valid.
module rs_dispatch
   import rezzmaster::*;
#(
   parameter int NUM_RS = 16,
   parameter int XLEN   = RS_XLEN
)(
   input  logic         clk,
   input  logic         rst,
   rs_dispatch_if.slave bus
);
   reservation_station r_rs [NUM_RS];
   logic               r_err;

   reservation_station w_nxt [NUM_RS];
   reservation_station w_new;
   logic [NUM_RS-1:0]  w_free_map;
   logic [NUM_RS-1:0]  w_free_sel;
   logic [NUM_RS-1:0]  w_inuse;
   logic [5:0]         w_pick_idx;
   logic               w_pick_any;
   logic               w_xfer;
   logic               w_cdb_hit;
   logic               w_bad_free;
   logic [XLEN-1:0]    w_cdb_val;
   logic [6:0]         w_cnt;

   always_comb begin
      for (int i = 0; i < NUM_RS; i++) begin
         w_inuse[i]    = r_rs[i].inuse;
         w_free_map[i] = ~r_rs[i].inuse;
         w_free_sel[i] = bus.free_valid && (bus.free_index == 6'(i));
      end
   end

   rs_pick_free #(.N(NUM_RS)) u_pick (
      .i_req (w_free_map),
      .index (w_pick_idx),
      .any   (w_pick_any)
   );

   assign w_xfer     = bus.in_valid && w_pick_any;
   assign w_cdb_hit  = bus.cdb_valid && (bus.cdb_tag != RS_TAG_NONE);
   assign w_cdb_val  = bus.cdb_value;
   // An out-of-range index never matches a select bit, so it falls out as a bad release.
   assign w_bad_free = bus.free_valid && ((w_free_sel & w_inuse) == '0);

   always_comb begin
      w_new       = '0;
      w_new.inuse = 1'b1;
      w_new.op    = bus.in_op;
      w_new.fu    = bus.in_fu;
      w_new.dest  = bus.in_dest;
      w_new.vj    = bus.in_vj;
      w_new.vk    = bus.in_vk;
      w_new.qj    = bus.in_qj;
      w_new.qk    = bus.in_qk;
      if (w_cdb_hit && bus.in_qj == bus.cdb_tag) begin
         w_new.vj = w_cdb_val;
         w_new.qj = RS_TAG_NONE;
      end
      if (w_cdb_hit && bus.in_qk == bus.cdb_tag) begin
         w_new.vk = w_cdb_val;
         w_new.qk = RS_TAG_NONE;
      end
   end

   always_comb begin
      w_nxt = r_rs;
      for (int i = 0; i < NUM_RS; i++) begin
         if (r_rs[i].inuse && w_cdb_hit) begin
            if (r_rs[i].qj == bus.cdb_tag) begin
               w_nxt[i].vj = w_cdb_val;
               w_nxt[i].qj = RS_TAG_NONE;
            end
            if (r_rs[i].qk == bus.cdb_tag) begin
               w_nxt[i].vk = w_cdb_val;
               w_nxt[i].qk = RS_TAG_NONE;
            end
         end
         if (w_free_sel[i] && r_rs[i].inuse) begin
            w_nxt[i].inuse = 1'b0;
         end
         // The allocated entry is free, so it can never also be the released one.
         if (w_xfer && w_pick_idx == 6'(i)) begin
            w_nxt[i] = w_new;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_RS; i++) begin
            r_rs[i] <= '0;
         end
         r_err <= 1'b0;
      end else begin
         r_rs <= w_nxt;
         if (w_bad_free) begin
            r_err <= 1'b1;
         end
      end
   end

   always_comb begin
      w_cnt = 7'd0;
      for (int i = 0; i < NUM_RS; i++) begin
         if (!r_rs[i].inuse) begin
            w_cnt = w_cnt + 7'd1;
         end
         bus.rs_ready[i] = r_rs[i].inuse && (r_rs[i].qj == RS_TAG_NONE) &&
                           (r_rs[i].qk == RS_TAG_NONE);
      end
   end

   assign bus.in_ready        = w_pick_any;
   assign bus.alloc_index     = w_pick_idx;
   assign bus.rstation        = r_rs;
   assign bus.free_count      = w_cnt;
   assign bus.err_double_free = r_err;
endmodule

// File: tb/tb_rs_dispatch.sv
// Bench for rs_dispatch: directed scenarios plus a randomized run against a behavioural station model.
module tb_rs_dispatch;
   import rezzmaster::*;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   rs_dispatch_if #(.NUM_RS(16), .XLEN(32)) bus ();

   rs_dispatch #(.NUM_RS(16), .XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   reservation_station m_rs [16];
   logic               m_err;

   // Station model: lowest free slot, CDB wake on occupied entries, bypass into the new entry.
   task automatic model_step();
      reservation_station nx [16];
      int a;
      int fi;
      if (rst) begin
         for (int i = 0; i < 16; i++) m_rs[i] = '0;
         m_err = 1'b0;
         return;
      end
      a = -1;
      for (int i = 15; i >= 0; i--) if (!m_rs[i].inuse) a = i;
      nx = m_rs;
      if (bus.cdb_valid && bus.cdb_tag != 0) begin
         for (int i = 0; i < 16; i++) begin
            if (m_rs[i].inuse && m_rs[i].qj == bus.cdb_tag) begin
               nx[i].vj = bus.cdb_value; nx[i].qj = 0;
            end
            if (m_rs[i].inuse && m_rs[i].qk == bus.cdb_tag) begin
               nx[i].vk = bus.cdb_value; nx[i].qk = 0;
            end
         end
      end
      fi = int'(bus.free_index);
      if (bus.free_valid) begin
         if (fi < 16 && m_rs[fi].inuse) nx[fi].inuse = 1'b0;
         else m_err = 1'b1;
      end
      if (bus.in_valid && a >= 0) begin
         nx[a].inuse = 1'b1;
         nx[a].op    = bus.in_op;
         nx[a].fu    = bus.in_fu;
         nx[a].dest  = bus.in_dest;
         nx[a].vj    = bus.in_vj;
         nx[a].vk    = bus.in_vk;
         nx[a].qj    = bus.in_qj;
         nx[a].qk    = bus.in_qk;
         if (bus.cdb_valid && bus.cdb_tag != 0 && bus.cdb_tag == bus.in_qj) begin
            nx[a].vj = bus.cdb_value; nx[a].qj = 0;
         end
         if (bus.cdb_valid && bus.cdb_tag != 0 && bus.cdb_tag == bus.in_qk) begin
            nx[a].vk = bus.cdb_value; nx[a].qk = 0;
         end
      end
      m_rs = nx;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid = 0; bus.in_op = 0; bus.in_fu = 0; bus.in_vj = 0; bus.in_vk = 0;
      bus.in_qj = 0; bus.in_qk = 0; bus.in_dest = 1;
      bus.free_valid = 0; bus.free_index = 0;
      bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_value = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      step();
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (bus.free_count !== 7'd16) begin
         n_fail++; $display("FAIL reset_free_count got %0d want 16", bus.free_count);
      end
      n_tests++;
      if (bus.in_ready !== 1'b1 || bus.alloc_index !== 6'd0) begin
         n_fail++; $display("FAIL reset_alloc got ready=%b idx=%0d want 1/0", bus.in_ready, bus.alloc_index);
      end
      n_tests++;
      if (bus.rs_ready !== 16'h0 || bus.err_double_free !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags got rs_ready=%h err=%b want 0/0", bus.rs_ready, bus.err_double_free);
      end
      for (int i = 0; i < 16; i++) begin
         n_tests++;
         if (bus.rstation[i] !== '0) begin
            n_fail++; $display("FAIL reset_entry%0d got %h want 0", i, bus.rstation[i]);
         end
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         bus.in_valid = 1; bus.in_op = 7'($urandom); bus.in_fu = 3'(1 << $urandom_range(0, 2));
         bus.in_vj = $urandom; bus.in_vk = $urandom; bus.in_qj = 0; bus.in_qk = 0;
         bus.in_dest = 6'(i + 1);
         n_tests++;
         if (bus.alloc_index !== 6'(i) || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL fill_alloc%0d got idx=%0d ready=%b want %0d/1", i, bus.alloc_index, bus.in_ready, i);
         end
         step();
      end
      n_tests++;
      if (bus.in_ready !== 1'b0 || bus.free_count !== 7'd0) begin
         n_fail++; $display("FAIL fill_full got ready=%b cnt=%0d want 0/0", bus.in_ready, bus.free_count);
      end
      n_tests++;
      if (bus.rs_ready !== 16'hFFFF) begin
         n_fail++; $display("FAIL fill_rs_ready got %h want ffff", bus.rs_ready);
      end
      bus.in_dest = 6'd63;
      step();
      n_tests++;
      if (bus.free_count !== 7'd0 || bus.rstation[0].dest !== 6'd1) begin
         n_fail++; $display("FAIL full_ignore got cnt=%0d dest0=%0d want 0/1", bus.free_count, bus.rstation[0].dest);
      end
      for (int i = 0; i < 16; i++) begin
         n_tests++;
         if (bus.rstation[i] !== m_rs[i]) begin
            n_fail++; $display("FAIL fill_entry%0d got %h want %h", i, bus.rstation[i], m_rs[i]);
         end
      end
   endtask

   task automatic test_release_full();
      bus.in_valid = 1; bus.in_dest = 6'd40;
      bus.free_valid = 1; bus.free_index = 6'd5;
      n_tests++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL release_same_cycle got ready=%b want 0", bus.in_ready);
      end
      step();
      n_tests++;
      if (bus.in_ready !== 1'b1 || bus.alloc_index !== 6'd5 || bus.free_count !== 7'd1) begin
         n_fail++; $display("FAIL release_next got ready=%b idx=%0d cnt=%0d want 1/5/1",
                            bus.in_ready, bus.alloc_index, bus.free_count);
      end
      bus.free_index = 6'd9;
      step();
      bus.free_valid = 0; bus.in_valid = 0;
      n_tests++;
      if (bus.free_count !== 7'd1 || bus.alloc_index !== 6'd9) begin
         n_fail++; $display("FAIL alloc_and_free got cnt=%0d idx=%0d want 1/9", bus.free_count, bus.alloc_index);
      end
      n_tests++;
      if (bus.rstation[5].inuse !== 1'b1 || bus.rstation[5].dest !== 6'd40 || bus.rstation[9].inuse !== 1'b0) begin
         n_fail++; $display("FAIL realloc_entry5 got inuse=%b dest=%0d inuse9=%b want 1/40/0",
                            bus.rstation[5].inuse, bus.rstation[5].dest, bus.rstation[9].inuse);
      end
   endtask

   task automatic test_cdb_wake();
      do_reset();
      bus.in_valid = 1; bus.in_qj = 6'd7; bus.in_qk = 0; bus.in_vj = 32'h1111; bus.in_dest = 6'd2;
      step();
      idle();
      n_tests++;
      if (bus.rstation[0].qj !== 6'd7 || bus.rs_ready[0] !== 1'b0) begin
         n_fail++; $display("FAIL wake_pre got qj=%0d rdy=%b want 7/0", bus.rstation[0].qj, bus.rs_ready[0]);
      end
      step();
      bus.cdb_valid = 1; bus.cdb_tag = 6'd7; bus.cdb_value = 32'hDEAD_BEEF;
      step();
      idle();
      n_tests++;
      if (bus.rstation[0].vj !== 32'hDEAD_BEEF || bus.rstation[0].qj !== 6'd0) begin
         n_fail++; $display("FAIL wake_value got vj=%h qj=%0d want deadbeef/0", bus.rstation[0].vj, bus.rstation[0].qj);
      end
      n_tests++;
      if (bus.rs_ready[0] !== 1'b1) begin
         n_fail++; $display("FAIL wake_ready got %b want 1", bus.rs_ready[0]);
      end
   endtask

   task automatic test_bypass();
      bus.in_valid = 1; bus.in_qj = 0; bus.in_qk = 6'd9; bus.in_vk = 32'h5555; bus.in_dest = 6'd4;
      bus.cdb_valid = 1; bus.cdb_tag = 6'd9; bus.cdb_value = 32'h1234;
      step();
      idle();
      n_tests++;
      if (bus.rstation[1].qk !== 6'd0 || bus.rstation[1].vk !== 32'h1234 || bus.rs_ready[1] !== 1'b1) begin
         n_fail++; $display("FAIL bypass got qk=%0d vk=%h rdy=%b want 0/1234/1",
                            bus.rstation[1].qk, bus.rstation[1].vk, bus.rs_ready[1]);
      end
   endtask

   task automatic test_bad_free();
      bus.free_valid = 1; bus.free_index = 6'd10;
      step();
      idle();
      n_tests++;
      if (bus.err_double_free !== 1'b1 || bus.free_count !== 7'd14) begin
         n_fail++; $display("FAIL bad_free_unused got err=%b cnt=%0d want 1/14", bus.err_double_free, bus.free_count);
      end
      bus.free_valid = 1; bus.free_index = 6'd0;
      step();
      idle();
      n_tests++;
      if (bus.err_double_free !== 1'b1 || bus.free_count !== 7'd15) begin
         n_fail++; $display("FAIL err_sticky got err=%b cnt=%0d want 1/15", bus.err_double_free, bus.free_count);
      end
      do_reset();
      bus.free_valid = 1; bus.free_index = 6'd20;
      n_tests++;
      if (bus.err_double_free !== 1'b0) begin
         n_fail++; $display("FAIL err_reset got %b want 0", bus.err_double_free);
      end
      step();
      idle();
      n_tests++;
      if (bus.err_double_free !== 1'b1 || bus.free_count !== 7'd16) begin
         n_fail++; $display("FAIL bad_free_range got err=%b cnt=%0d want 1/16", bus.err_double_free, bus.free_count);
      end
   endtask

   task automatic test_rst_mid();
      do_reset();
      bus.in_valid = 1; bus.in_qj = 6'd3;
      for (int i = 0; i < 8; i++) begin
         bus.in_dest = 6'(i + 1);
         step();
      end
      n_tests++;
      if (bus.free_count !== 7'd8) begin
         n_fail++; $display("FAIL half_full got %0d want 8", bus.free_count);
      end
      rst = 1; bus.cdb_valid = 1; bus.cdb_tag = 6'd3;
      step();
      rst = 0;
      idle();
      n_tests++;
      if (bus.free_count !== 7'd16 || bus.alloc_index !== 6'd0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid got cnt=%0d idx=%0d ready=%b want 16/0/1",
                            bus.free_count, bus.alloc_index, bus.in_ready);
      end
      for (int i = 0; i < 16; i++) begin
         n_tests++;
         if (bus.rstation[i] !== '0) begin
            n_fail++; $display("FAIL rst_mid_entry%0d got %h want 0", i, bus.rstation[i]);
         end
      end
   endtask

   task automatic test_random();
      int exp_idx;
      int exp_cnt;
      logic [15:0] exp_rdy;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         bus.in_valid   = ($urandom_range(0, 9) < 6);
         bus.in_op      = 7'($urandom);
         bus.in_fu      = 3'(1 << $urandom_range(0, 2));
         bus.in_vj      = $urandom;
         bus.in_vk      = $urandom;
         bus.in_qj      = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 10)) : 6'd0;
         bus.in_qk      = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 10)) : 6'd0;
         bus.in_dest    = 6'($urandom_range(1, 63));
         bus.free_valid = ($urandom_range(0, 9) < 4);
         bus.free_index = 6'($urandom_range(0, 17));
         bus.cdb_valid  = ($urandom_range(0, 1) == 1);
         bus.cdb_tag    = 6'($urandom_range(0, 10));
         bus.cdb_value  = $urandom;
         exp_idx = 0; exp_cnt = 0;
         for (int i = 15; i >= 0; i--) if (!m_rs[i].inuse) begin exp_idx = i; exp_cnt++; end
         n_tests++;
         if (bus.alloc_index !== 6'(exp_idx) || bus.in_ready !== (exp_cnt != 0) || bus.free_count !== 7'(exp_cnt)) begin
            n_fail++; $display("FAIL rand_alloc c=%0d got idx=%0d ready=%b cnt=%0d want %0d/%b/%0d",
                               c, bus.alloc_index, bus.in_ready, bus.free_count, exp_idx, exp_cnt != 0, exp_cnt);
         end
         step();
         for (int i = 0; i < 16; i++) begin
            exp_rdy[i] = m_rs[i].inuse && m_rs[i].qj == 0 && m_rs[i].qk == 0;
            n_tests++;
            if (bus.rstation[i] !== m_rs[i]) begin
               n_fail++; $display("FAIL rand_entry c=%0d i=%0d got %h want %h", c, i, bus.rstation[i], m_rs[i]);
            end
         end
         n_tests++;
         if (bus.rs_ready !== exp_rdy || bus.err_double_free !== m_err) begin
            n_fail++; $display("FAIL rand_flags c=%0d got rdy=%h err=%b want %h/%b",
                               c, bus.rs_ready, bus.err_double_free, exp_rdy, m_err);
         end
      end
      idle();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1;
      m_err   = 0;
      for (int i = 0; i < 16; i++) m_rs[i] = '0;
      idle();
      #1;
      test_reset();
      test_fill();
      test_release_full();
      test_cdb_wake();
      test_bypass();
      test_bad_free();
      test_rst_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/rs_dispatch.md
# rs_dispatch

Dispatch-side writer for the reservation-station array. It accepts one decoded instruction per cycle and allocates the lowest-numbered free entry, where it writes the operands and sets `inuse`. It snoops the common data bus (CDB) to wake up waiting operands, and takes entry-release requests back from the issue stage, which clears `inuse` when it sends an entry to a functional unit. It sits between decode and issue and owns the only stored copy of the station contents.

## Interface
Parameters:
- `NUM_RS`, 16: number of station entries; legal range 2..64, so indices fit `[5:0]`.
- `XLEN`, 32: operand width.

Ports:
- `clk`  in  1  clock; every register updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  an entry is free; the transfer happens when `in_valid && in_ready`.
- `in_op`  in  7  opcode (`op_type`).
- `in_fu`  in  3  one-hot functional-unit class.
- `in_vj`, `in_vk`  in  XLEN  operand values; meaningful only when the matching tag is 0.
- `in_qj`, `in_qk`  in  6  producer tags; 0 means the value is present.
- `in_dest`  in  6  destination tag (nonzero).
- `alloc_index`  out  6  entry written by the current transfer; combinational.
- `free_valid`  in  1  issue releases an entry.
- `free_index`  in  6  entry being released.
- `cdb_valid`  in  1  result broadcast.
- `cdb_tag`  in  6  tag of the broadcast result.
- `cdb_value`  in  XLEN  broadcast value.
- `rstation`  out  `reservation_station`  full station array; this is the issue stage's input.
- `rs_ready`  out  NUM_RS  per entry: `inuse && qj==0 && qk==0`.
- `free_count`  out  7  number of entries with `inuse==0`.
- `err_double_free`  out  1  sticky error flag.

## Operation
- Entry fields: `inuse`, `op`, `fu`, `vj`, `vk`, `qj`, `qk`, `dest`.
- Allocation:
  - On a transfer, the entry at index `alloc_index` is written with the input fields, and `inuse` is set to 1.
  - `alloc_index` is the lowest index with `inuse==0` in the registered bitmap.
- Release: when `free_valid` is high and `inuse[free_index]` is 1, `inuse` is cleared. All other fields keep their values.
- Bad release: a release naming an entry with `inuse==0`, or with `free_index>=NUM_RS`, changes nothing and sets `err_double_free`. The flag is cleared only by `rst`.
- CDB wake-up: when `cdb_valid` is high and `cdb_tag!=0`:
  - every in-use entry with `qj==cdb_tag` gets `vj<=cdb_value` and `qj<=0`;
  - `qk`/`vk` are handled the same way.
- CDB bypass on allocation: if the same-cycle CDB tag matches `in_qj` (or `in_qk`), the new entry stores `cdb_value` with its tag at 0.
- Simultaneous events:
  - Allocation and release in the same cycle are independent, and both take effect.
  - An entry released in cycle N can be allocated no earlier than cycle N+1, because `in_ready` and `alloc_index` come from registered state only.
- Full: `free_count==0` forces `in_ready=0`, and `in_valid` is then ignored.
- Reset:
  - All `inuse` bits, `qj`, `qk` and all data fields go to 0.
  - `free_count=NUM_RS`, `in_ready=1`, `alloc_index=0`, `rs_ready=0`, `err_double_free=0`.
  - Reset overrides any same-cycle transfer, release or CDB event.

## Timing
- Allocation latency 1 cycle: an entry transferred in cycle N shows in `rstation` and `rs_ready` in cycle N+1.
- `rs_ready` for an operand woken by the CDB in cycle N rises in cycle N+1.
- Release in cycle N: `inuse` is 0 and `free_count` is incremented in cycle N+1.
- `free_count` change per cycle: +1 on release, −1 on allocation, net 0 when both occur.
- `in_ready` depends only on registered state, with no combinational path from `in_valid`. Decode may hold `in_valid` high across stalls.
- Throughput: one allocation per cycle while any entry is free.

## Structure
- The `reservation_station` typedef and a `RS_TAG_NONE=6'd0` constant are added to package `rezzmaster`.
- Sub-module `rs_pick_free`: a parameterised lowest-set-bit priority encoder over `~inuse`, with outputs `index[5:0]` and `any`. It is reused later by the issue-side selector.
- Everything else lives in one clocked process plus combinational next-state logic.

## Test plan
- Reset, then 16 back-to-back allocations with tags 0:
  - `alloc_index` steps 0..15 and `in_ready` drops after the 16th;
  - `free_count` reaches 0 and every `rs_ready` bit is 1.
- Full station, then release entry 5 in cycle N:
  - `in_ready` goes to 1 in N+1 and the next allocation lands in entry 5.
  - Also, in the same cycle, allocate and release with `free_count==1`: `free_count` stays 1.
- Allocation with `qj=7`, `qk=0`, then `cdb_valid`, `cdb_tag=7`, `cdb_value=32'hDEAD_BEEF` two cycles later:
  - `vj` becomes `DEAD_BEEF` and `qj` becomes 0;
  - `rs_ready` for the entry rises the next cycle.
- Allocation with `in_qk=9` in the same cycle as a CDB broadcast of tag 9, value `32'h1234`: the stored entry has `qk=0`, `vk=32'h1234`.
- Release of an entry with `inuse==0`, and release of index 20 with `NUM_RS=16`: the state is unchanged and `err_double_free` latches to 1 until `rst`.
- Assert `rst` in the middle of a stream of allocations, with the station half full and `in_valid` high: the next cycle shows all `inuse=0`, `free_count=16` and `alloc_index=0`.
